// File: rtl/guess_game_ctrl.sv
// Sequencer for the two-digit number-guessing game: it captures a secret number,
// narrows the displayed low/high bounds after each guess, and shows win or lose.
module guess_game_ctrl #(
  parameter int MAX_TRIES = 7,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  output logic [3:0] o_digit_3,
  output logic [3:0] o_digit_2,
  output logic [3:0] o_digit_1,
  output logic [3:0] o_digit_0,
  output logic       o_win,
  output logic       o_lose,
  output logic [3:0] o_tries
);

  typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_WIN, S_LOSE} state_t;

  localparam int             BW            = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]  LP_BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0]     LP_MAX_TRIES  = 4'(MAX_TRIES);
  localparam logic [3:0]     LP_BLANK      = 4'hF;

  state_t        r_state, w_next_state;
  logic [3:0]    r_sctr_t, r_sctr_o;
  logic [3:0]    r_sec_t, r_sec_o;
  logic [3:0]    r_low_t, r_low_o;
  logic [3:0]    r_high_t, r_high_o;
  logic [3:0]    r_guess_t, r_guess_o;
  logic [1:0]    r_n;
  logic [3:0]    r_tries;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_off;

  // BCD digits are each 0-9, so a packed 8-bit compare equals tens-first, ones-second.
  logic [7:0] w_guess, w_low, w_high, w_secret;
  logic       w_invalid, w_hit, w_below;
  logic [3:0] w_tries_inc;
  logic       w_is_digit, w_is_enter, w_is_clear;

  assign w_guess     = {r_guess_t, r_guess_o};
  assign w_low       = {r_low_t, r_low_o};
  assign w_high      = {r_high_t, r_high_o};
  assign w_secret    = {r_sec_t, r_sec_o};
  assign w_invalid   = (w_guess < w_low) || (w_guess > w_high);
  assign w_hit       = (w_guess == w_secret);
  assign w_below     = (w_guess < w_secret);
  assign w_tries_inc = r_tries + 4'd1;
  assign w_is_digit  = i_key_valid && (i_key_code <= 4'd9);
  assign w_is_enter  = i_key_valid && (i_key_code == 4'd10);
  assign w_is_clear  = i_key_valid && (i_key_code == 4'd11);
  assign o_tries     = r_tries;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    o_digit_3    = LP_BLANK;
    o_digit_2    = LP_BLANK;
    o_digit_1    = LP_BLANK;
    o_digit_0    = LP_BLANK;
    o_win        = 1'b0;
    o_lose       = 1'b0;

    if (i_start) begin
      w_next_state = S_ENTRY;
    end else begin
      case (r_state)
        S_ENTRY: if (w_is_enter && (r_n != 2'd0)) w_next_state = S_CHECK;
        S_CHECK: begin
          if (w_invalid)                        w_next_state = S_ENTRY;
          else if (w_hit)                       w_next_state = S_WIN;
          else if (w_tries_inc == LP_MAX_TRIES) w_next_state = S_LOSE;
          else                                  w_next_state = S_ENTRY;
        end
        default: w_next_state = r_state;
      endcase
    end

    case (r_state)
      S_ENTRY, S_CHECK: begin
        if (r_n == 2'd0) begin
          o_digit_3 = r_low_t;
          o_digit_2 = r_low_o;
          o_digit_1 = r_high_t;
          o_digit_0 = r_high_o;
        end else if (r_n == 2'd1) begin
          o_digit_2 = r_guess_o;
        end else begin
          o_digit_3 = r_guess_t;
          o_digit_2 = r_guess_o;
        end
      end
      S_WIN: begin
        o_win = 1'b1;
        if (!r_blink_off) begin
          o_digit_2 = r_tries;
          o_digit_1 = r_sec_t;
          o_digit_0 = r_sec_o;
        end
      end
      S_LOSE: begin
        o_lose    = 1'b1;
        o_digit_1 = r_sec_t;
        o_digit_0 = r_sec_o;
      end
      default: ;
    endcase
  end

  // Free-running BCD counter that supplies the secret on start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sctr_t <= 4'd0;
      r_sctr_o <= 4'd0;
    end else if (r_sctr_o == 4'd9) begin
      r_sctr_o <= 4'd0;
      r_sctr_t <= (r_sctr_t == 4'd9) ? 4'd0 : r_sctr_t + 4'd1;
    end else begin
      r_sctr_o <= r_sctr_o + 4'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sec_t   <= 4'd0;
      r_sec_o   <= 4'd0;
      r_low_t   <= 4'd0;
      r_low_o   <= 4'd0;
      r_high_t  <= 4'd9;
      r_high_o  <= 4'd9;
      r_guess_t <= 4'd0;
      r_guess_o <= 4'd0;
      r_n       <= 2'd0;
      r_tries   <= 4'd0;
    end else if (i_start) begin
      r_sec_t  <= r_sctr_t;
      r_sec_o  <= r_sctr_o;
      r_low_t  <= 4'd0;
      r_low_o  <= 4'd0;
      r_high_t <= 4'd9;
      r_high_o <= 4'd9;
      r_n      <= 2'd0;
      r_tries  <= 4'd0;
    end else if (r_state == S_ENTRY) begin
      if (w_is_digit && (r_n == 2'd0)) begin
        r_guess_t <= 4'd0;
        r_guess_o <= i_key_code;
        r_n       <= 2'd1;
      end else if (w_is_digit && (r_n == 2'd1)) begin
        r_guess_t <= r_guess_o;
        r_guess_o <= i_key_code;
        r_n       <= 2'd2;
      end else if (w_is_clear) begin
        r_n <= 2'd0;
      end
    end else if (r_state == S_CHECK) begin
      r_n <= 2'd0;
      if (!w_invalid) begin
        r_tries <= w_tries_inc;
        // A guess below the secret is at most 98 and one above it at least 01, so +-1 never wraps.
        if (!w_hit && w_below) begin
          if (r_guess_o == 4'd9) begin
            r_low_t <= r_guess_t + 4'd1;
            r_low_o <= 4'd0;
          end else begin
            r_low_t <= r_guess_t;
            r_low_o <= r_guess_o + 4'd1;
          end
        end else if (!w_hit) begin
          if (r_guess_o == 4'd0) begin
            r_high_t <= r_guess_t - 4'd1;
            r_high_o <= 4'd9;
          end else begin
            r_high_t <= r_guess_t;
            r_high_o <= r_guess_o - 4'd1;
          end
        end
      end
    end
  end

  // Blink timer idles cleared outside WIN so every win starts in the on phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_state != S_WIN) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (r_blink_cnt == LP_BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink_off <= ~r_blink_off;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

endmodule
